// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default width,
// op-code encodings and FSM state encoding.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: {acc_hi, acc_lo} is the partial product with the multiplier in
// acc_lo; add the multiplicand when the multiplier LSB is set, then shift right.
// Divide: acc_hi is the partial remainder and acc_lo holds the dividend bits
// still to be shifted in (quotient bits enter from the right).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd_b,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] restore_hi;

    // Select shift-add or restoring subtract for this step
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
        next_hi    = acc_hi;
        next_lo    = acc_lo;
        sum        = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        diff       = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd_b};
        restore_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        if (is_div) begin
            // A clear top bit of diff means the shifted remainder was >= divisor.
            if (!diff[WIDTH]) begin
                next_hi = diff[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = restore_hi;
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit for the execute stage.
// Owns HI/LO; busy_e stalls the front of the pipe while an op iterates.
// Signed ops run on operand magnitudes; signs are applied in the FIX state.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock_e,
    input  logic             reset_n_e,
    input  logic             start_e,
    input  logic [2:0]       op_e,
    input  logic [WIDTH-1:0] src_a_e,
    input  logic [WIDTH-1:0] src_b_e,
    input  logic             flush_e,
    output logic             busy_e,
    output logic             done_e,
    output logic [WIDTH-1:0] hi_e,
    output logic [WIDTH-1:0] lo_e
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               is_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   opnd_b;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    logic               issue_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign busy_e = (state != ST_IDLE);

    // Operand magnitudes for issue: signed ops strip the sign here
    always_comb begin
        issue_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
        mag_a        = (issue_signed && src_a_e[WIDTH-1]) ? -src_a_e : src_a_e;
        mag_b        = (issue_signed && src_b_e[WIDTH-1]) ? -src_b_e : src_b_e;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .opnd_b  (opnd_b),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign fix-up and divide-by-zero override for the HI/LO write in FIX
    always_comb begin
        prod_mag = {acc_hi, acc_lo};
        prod_fix = (is_signed && (sa ^ sb)) ? -prod_mag : prod_mag;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            // Remainder takes the dividend's sign, which also restores the
            // original dividend when dividing by zero.
            fix_hi = (is_signed && sa) ? -acc_hi : acc_hi;
            if (opnd_b == '0) begin
                fix_lo = '1;
            end else begin
                fix_lo = (is_signed && (sa ^ sb)) ? -acc_lo : acc_lo;
            end
        end
    end

    // FSM, step counter, datapath registers and HI/LO
    always_ff @(posedge clock_e or negedge reset_n_e) begin
        // NOTE: there are no memories here, so every register is cleared on reset, including the datapath.
        if (!reset_n_e) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            opnd_b    <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            hi_e      <= '0;
            lo_e      <= '0;
            done_e    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done_e <= 1'b0;
            if (flush_e) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_e) begin
                            case (op_e)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    is_div    <= op_e[1];
                                    is_signed <= issue_signed;
                                    sa        <= src_a_e[WIDTH-1];
                                    sb        <= src_b_e[WIDTH-1];
                                    acc_hi    <= '0;
                                    acc_lo    <= mag_a;
                                    opnd_b    <= mag_b;
                                    cnt       <= CW'(WIDTH - 1);
                                    state     <= ST_RUN;
                                end
                                OP_MTHI: hi_e <= src_a_e;
                                OP_MTLO: lo_e <= src_a_e;
                                default: ;
                            endcase
                        end
                    end
                    ST_RUN: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        hi_e   <= fix_hi;
                        lo_e   <= fix_lo;
                        done_e <= 1'b1;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit. Stimulus pushes expected HI/LO and the
// expected done cycle into a queue; a monitor pops and compares on done_e.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock_e   = 1'b0;
    logic         reset_n_e = 1'b0;
    logic         start_e   = 1'b0;
    logic         flush_e   = 1'b0;
    logic [2:0]   op_e      = 3'b000;
    logic [W-1:0] src_a_e   = '0;
    logic [W-1:0] src_b_e   = '0;
    logic         busy_e;
    logic         done_e;
    logic [W-1:0] hi_e;
    logic [W-1:0] lo_e;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock_e   (clock_e),
        .reset_n_e (reset_n_e),
        .start_e   (start_e),
        .op_e      (op_e),
        .src_a_e   (src_a_e),
        .src_b_e   (src_b_e),
        .flush_e   (flush_e),
        .busy_e    (busy_e),
        .done_e    (done_e),
        .hi_e      (hi_e),
        .lo_e      (lo_e)
    );

    always #5 clock_e = ~clock_e;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clock_e) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done_e pulse must match the oldest outstanding result
    always @(negedge clock_e) begin : monitor
        exp_t e;
        if (reset_n_e && done_e) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done_e), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_hi"}, 64'(hi_e), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo_e), 64'(e.lo));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                check({e.name, "_busy"}, 64'(busy_e), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock_e);
        #1;
    endtask

    // Result of an op issued now is due in the done cycle 34 cycles later
    task automatic expect_res(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_t e;
        e.name = name;
        e.hi   = hi;
        e.lo   = lo;
        e.cyc  = cyc + 34;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_e    = op;
        src_a_e = a;
        src_b_e = b;
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && busy_e; i++) tick();
        check({name, "_idle_timeout"}, 64'(busy_e), 64'd0);
        tick();
    endtask

    initial begin : stim
        int seen;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 64'(busy_e), 64'd0);
        check("rst_done", 64'(done_e), 64'd0);
        check("rst_hi", 64'(hi_e), 64'd0);
        check("rst_lo", 64'(lo_e), 64'd0);
        reset_n_e = 1'b1;
        tick();

        // MTHI in IDLE: visible next cycle, never busy, no done
        issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_hi", 64'(hi_e), 64'hDEADBEEF);
        check("mthi_busy", 64'(busy_e), 64'd0);
        check("mthi_done", 64'(done_e), 64'd0);
        tick();

        // Multiply and divide vectors
        expect_res("mult_m2x3", 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue(OP_MULT, 32'hFFFFFFFE, 32'h3);
        check("mult_busy_after_issue", 64'(busy_e), 64'd1);
        wait_idle("mult_m2x3");

        expect_res("multu_max", 32'hFFFFFFFE, 32'h00000001);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle("multu_max");

        expect_res("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
        wait_idle("div_m7d2");

        expect_res("div_ovf", 32'h0, 32'h80000000);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("div_ovf");

        expect_res("divu_by0", 32'h7, 32'hFFFFFFFF);
        issue(OP_DIVU, 32'h7, 32'h0);
        wait_idle("divu_by0");

        // Start while busy is ignored; new op issued in the done cycle
        expect_res("divu_100d3", 32'h1, 32'd33);
        issue(OP_DIVU, 32'd100, 32'd3);
        repeat (4) tick();
        issue(OP_MULTU, 32'd5, 32'd5);
        check("ignored_start_busy", 64'(busy_e), 64'd1);
        for (int i = 0; i < 60 && !done_e; i++) tick();
        check("b2b_done_seen", 64'(done_e), 64'd1);
        expect_res("multu_b2b", 32'h0, 32'd25);
        issue(OP_MULTU, 32'd5, 32'd5);
        check("b2b_busy", 64'(busy_e), 64'd1);
        wait_idle("multu_b2b");

        // Flush in RUN: HI/LO untouched, no done
        issue(OP_MTLO, 32'h00001234, 32'h0);
        check("mtlo_lo", 64'(lo_e), 64'h1234);
        issue(OP_DIVU, 32'd100, 32'd3);
        repeat (9) tick();
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        check("flush_busy", 64'(busy_e), 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done_e) seen++;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_lo", 64'(lo_e), 64'h1234);
        check("flush_hi", 64'(hi_e), 64'h0);

        // Flush beats start, even for MTHI
        op_e    = OP_MTHI;
        src_a_e = 32'h55;
        start_e = 1'b1;
        flush_e = 1'b1;
        tick();
        start_e = 1'b0;
        flush_e = 1'b0;
        check("flush_start_hi", 64'(hi_e), 64'h0);
        check("flush_start_busy", 64'(busy_e), 64'd0);

        // Asynchronous reset mid-DIV
        issue(OP_MTHI, 32'hCAFEF00D, 32'h0);
        check("mthi2_hi", 64'(hi_e), 64'hCAFEF00D);
        issue(OP_DIV, 32'hFFFFFF9C, 32'd7);
        repeat (14) tick();
        #2 reset_n_e = 1'b0;
        #1;
        check("arst_busy", 64'(busy_e), 64'd0);
        check("arst_hi", 64'(hi_e), 64'h0);
        check("arst_lo", 64'(lo_e), 64'h0);
        check("arst_done", 64'(done_e), 64'd0);
        tick();
        tick();
        reset_n_e = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (done_e) seen++;
        end
        check("arst_no_done", 64'(seen), 64'd0);
        check("arst_busy_after", 64'(busy_e), 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
